// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to two execution combos per cycle onto the two CDB lanes.
// Latency: 1 cycle, registered selects/grant/busy; a grant lasts exactly one cycle.
// Backpressure: stall forces both lanes idle and freezes the pointer; pending requests are kept.
module cdb_arbiter #(
    parameter int          N_REQ        = 8,
    parameter logic [7:0]  BASE_ADDRESS = 8'h00,
    parameter logic [7:0]  IDLE_ADDRESS = 8'hFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    input  logic             stall,
    output logic [7:0]       select_0,
    output logic [7:0]       select_1,
    output logic [N_REQ-1:0] grant,
    output logic             busy
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]    ptr;
    logic [N_REQ-1:0] eff;
    logic             found_0;
    logic             found_1;
    logic [PW-1:0]    win_0;
    logic [PW-1:0]    win_1;

    // A combo granted this cycle still shows its request; mask it so it is not re-granted.
    assign eff = request & ~grant;

    always_comb begin
        found_0 = 1'b0;
        found_1 = 1'b0;
        win_0   = '0;
        win_1   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N_REQ;
            if (!found_0 && eff[idx]) begin
                found_0 = 1'b1;
                win_0   = PW'(idx);
            end
        end
        // Lane 1 continues the circular scan just past the lane 0 winner.
        for (int k = 1; k < N_REQ; k++) begin
            int idx;
            idx = (int'(win_0) + k) % N_REQ;
            if (found_0 && !found_1 && eff[idx]) begin
                found_1 = 1'b1;
                win_1   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            select_0 <= IDLE_ADDRESS;
            select_1 <= IDLE_ADDRESS;
            grant    <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
        end else if (stall || !found_0) begin
            select_0 <= IDLE_ADDRESS;
            select_1 <= IDLE_ADDRESS;
            grant    <= '0;
            busy     <= 1'b0;
        end else begin
            select_0 <= BASE_ADDRESS + 8'(win_0);
            busy     <= 1'b1;
            if (found_1) begin
                select_1 <= BASE_ADDRESS + 8'(win_1);
                grant    <= (N_REQ'(1) << win_0) | (N_REQ'(1) << win_1);
                ptr      <= PW'((int'(win_1) + 1) % N_REQ);
            end else begin
                select_1 <= IDLE_ADDRESS;
                grant    <= N_REQ'(1) << win_0;
                ptr      <= PW'((int'(win_0) + 1) % N_REQ);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round-robin pairs, wrap, stale-request mask, stall, reset mid-grant.
module tb_cdb_arbiter;

    logic       clock;
    logic       reset;
    logic [7:0] request;
    logic       stall;
    logic [7:0] select_0;
    logic [7:0] select_1;
    logic [7:0] grant;
    logic       busy;

    int errs   = 0;
    int checks = 0;

    cdb_arbiter #(
        .N_REQ        (8),
        .BASE_ADDRESS (8'h00),
        .IDLE_ADDRESS (8'hFF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .request  (request),
        .stall    (stall),
        .select_0 (select_0),
        .select_1 (select_1),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] g, input logic b);
        check({tag, ".sel0"},  32'(select_0), 32'(s0));
        check({tag, ".sel1"},  32'(select_1), 32'(s1));
        check({tag, ".grant"}, 32'(grant),    32'(g));
        check({tag, ".busy"},  32'(busy),     32'(b));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clock   = 1'b0;
        reset   = 1'b0;
        request = 8'hFF;
        stall   = 1'b0;

        #23;
        chk_out("rst_hold", 8'hFF, 8'hFF, 8'h00, 1'b0);
        tick();
        reset = 1'b1;

        // Round-robin pairs with each winner dropping its request in its grant cycle
        tick(); chk_out("rr01", 8'h00, 8'h01, 8'h03, 1'b1); request = 8'hFC;
        tick(); chk_out("rr23", 8'h02, 8'h03, 8'h0C, 1'b1); request = 8'hF0;
        tick(); chk_out("rr45", 8'h04, 8'h05, 8'h30, 1'b1); request = 8'hC0;
        tick(); chk_out("rr67", 8'h06, 8'h07, 8'hC0, 1'b1); request = 8'h00;
        tick(); chk_out("rr_idle", 8'hFF, 8'hFF, 8'h00, 1'b0); request = 8'hFF;
        tick(); chk_out("rr01_again", 8'h00, 8'h01, 8'h03, 1'b1); request = 8'h00;
        tick(); chk_out("rr_idle2", 8'hFF, 8'hFF, 8'h00, 1'b0);

        // Single requester (ptr = 2)
        request = 8'h04;
        tick(); chk_out("single", 8'h02, 8'hFF, 8'h04, 1'b1); request = 8'h00;
        tick(); chk_out("single_after", 8'hFF, 8'hFF, 8'h00, 1'b0);

        // Combo 3 holds its request: granted every other cycle
        request = 8'h08;
        tick(); chk_out("mask1", 8'h03, 8'hFF, 8'h08, 1'b1);
        tick(); chk_out("mask0", 8'hFF, 8'hFF, 8'h00, 1'b0);
        tick(); chk_out("mask1b", 8'h03, 8'hFF, 8'h08, 1'b1);
        tick(); chk_out("mask0b", 8'hFF, 8'hFF, 8'h00, 1'b0);
        request = 8'h00;
        tick();

        // Stall for three cycles with combos 4 and 5 pending (ptr = 4)
        request = 8'h30;
        stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("stall", 8'hFF, 8'hFF, 8'h00, 1'b0);
        end
        stall = 1'b0;
        tick(); chk_out("post_stall", 8'h04, 8'h05, 8'h30, 1'b1); request = 8'h00;
        tick();

        // Lane 1 scan wraps from 7 to 0 (ptr = 6 -> 7)
        request = 8'h40;
        tick(); chk_out("wrap_a", 8'h06, 8'hFF, 8'h40, 1'b1); request = 8'h81;
        tick(); chk_out("wrap_b", 8'h07, 8'h00, 8'h81, 1'b1); request = 8'h00;
        tick();

        // Reset while select_0 = 6; ptr would otherwise be 7
        request = 8'h40;
        tick(); chk_out("pre_rst", 8'h06, 8'hFF, 8'h40, 1'b1);
        #2 reset = 1'b0;
        #1 chk_out("async_rst", 8'hFF, 8'hFF, 8'h00, 1'b0);
        request = 8'h83;
        tick();
        reset = 1'b1;
        tick(); chk_out("post_rst", 8'h00, 8'h01, 8'h03, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Central arbiter for the two common data bus lanes.
- Takes write-back requests from up to N_REQ execution combos (ALU, branch, load/store, ...) and grants up to two per cycle, round-robin.
- Broadcasts each winner's 8-bit address on the lane select lines. Each combo's local arbiter compares that address against its own to obtain bus_granted and pop its reservation station.
- Sits directly downstream of the execution combos and upstream of the ROB/station snoop on the common data bus.

Parameters:
- N_REQ, 8, number of requesting combos (2..16).
- BASE_ADDRESS, 8'h00, address of requester 0; requester i has address BASE_ADDRESS+i.
- IDLE_ADDRESS, 8'hFF, select value meaning "lane unused"; must lie outside BASE_ADDRESS..BASE_ADDRESS+N_REQ-1.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- request  input  N_REQ  bit i high = combo i holds a result for the bus
- stall  input  1  ROB back-pressure; no new grants while high
- select_0  output  8  address of combo owning lane 0 this cycle
- select_1  output  8  address of combo owning lane 1 this cycle
- grant  output  N_REQ  one-hot-or-two-hot mirror of the selects
- busy  output  1  at least one lane granted this cycle

Behaviour:
- Reset: while reset is low, the following hold asynchronously:
  - select_0 = select_1 = IDLE_ADDRESS
  - grant = 0, busy = 0
  - round-robin pointer ptr = 0
- Registered outputs, latency 1. Requests sampled at rising edge t appear as selects/grant during cycle t+1, for exactly one cycle.
- The granted combo drives its result onto the lane during the cycle its address is on the select line. It drops its request combinationally in that same cycle.
- Effective request: eff[i] = request[i] & ~grant[i]. A combo is never granted in two consecutive cycles on a stale request. Back-to-back results from one combo are granted at most every other cycle.
- Lane 0 winner: first i with eff[i]=1, scanning circularly from ptr.
- Lane 1 winner: next i with eff[i]=1 after the lane 0 winner, scanning circularly and excluding the lane 0 winner.
- Pointer update:
  - After two grants: ptr = (lane 1 winner + 1) mod N_REQ.
  - After one grant: ptr = (lane 0 winner + 1) mod N_REQ.
  - After no grant: ptr unchanged.
- Unused lane: a single effective requester takes lane 0 only. select_1 = IDLE_ADDRESS and its grant bit is absent. Lane 1 is never used while lane 0 is idle.
- grant[i] = 1 iff select_0 or select_1 equals BASE_ADDRESS+i. busy = (select_0 != IDLE_ADDRESS).
- Stall: stall sampled high at edge t gives both lanes IDLE_ADDRESS, grant = 0 and ptr unchanged in cycle t+1. Requests remain pending; nothing is lost.
- Pointer wrap: ptr wraps from N_REQ-1 to 0. The scan is modulo N_REQ for any pointer position.
- Reset mid-operation: outputs are forced idle immediately. No grant survives reset, and pending requesters re-arbitrate from ptr = 0.
- Fairness: with all N_REQ requesting continuously, every combo is granted within ceil(N_REQ/2)+1 cycles.

Test Plan:
- Reset: hold reset low with request=8'hFF -> select_0 = select_1 = 8'hFF, grant = 0, busy = 0; first cycle after release grants combos 0 and 1 (select_0 = 8'h00, select_1 = 8'h01).
- Single requester: request = 8'b0000_0100 for one cycle -> next cycle select_0 = 8'h02, select_1 = 8'hFF, grant = 8'h04; following cycle all idle.
- Round-robin wrap: request = 8'hFF held constant with each granted combo dropping its request in its grant cycle -> grant pairs (0,1), (2,3), (4,5), (6,7), then (0,1) again after the requests are reasserted.
- Consecutive-grant mask: combo 3 requests continuously and is the only requester -> grant[3] alternates 1,0,1,0; never high in two successive cycles.
- Stall: request = 8'h30 with stall high for 3 cycles -> selects stay 8'hFF and ptr is unchanged; the cycle after stall drops gives select_0 = 8'h04, select_1 = 8'h05.
- Reset mid-grant: assert reset while select_0 = 8'h06 -> select_0 becomes 8'hFF without waiting for a clock edge; after release, arbitration restarts from combo 0.
